// File: rtl/nar_pkg.sv
// Shared types and default word format for the neuron feeder slice.
package nar_pkg;

    localparam int unsigned N_DEF = 10;
    localparam int unsigned Q_DEF = 9;
    localparam int unsigned K_DEF = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLR    = 3'd1,
        STREAM = 3'd2,
        BIAS   = 3'd3,
        CAP    = 3'd4,
        RESULT = 3'd5
    } state_t;

endpackage

// File: rtl/neuron_feeder_if.sv
// Sample-in and result-out valid/ready streams of the neuron feeder.
interface neuron_feeder_if
    import nar_pkg::*;
#(
    parameter int unsigned N = N_DEF
) ();

    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_x;
    logic         res_valid;
    logic         res_ready;
    logic [N-1:0] res_data;

    // Host side: produces samples, consumes results.
    modport master (
        output in_valid, in_x, res_ready,
        input  in_ready, res_valid, res_data
    );

    // Feeder side: consumes samples, produces results.
    modport slave (
        input  in_valid, in_x, res_ready,
        output in_ready, res_valid, res_data
    );

endinterface

// File: rtl/neuron_feeder_regfile.sv
// K x N storage with one write port and one combinational indexed read port.
module neuron_feeder_regfile #(
    parameter int unsigned N  = 10,
    parameter int unsigned K  = 8,
    parameter int unsigned AW = $clog2(K)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [N-1:0]  i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [N-1:0]  o_rdata_c
);

    logic [N-1:0] r_mem [K];

    // Storage update; reset clears every entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem <= '{default: '0};
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_c = r_mem[i_raddr];

endmodule

// File: rtl/neuron_feeder.sv
// Drives one MAC neuron: collects K samples, streams (w,x) pairs, presents
// the bias, captures the neuron output and returns it on the result port.
module neuron_feeder
    import nar_pkg::*;
#(
    parameter int unsigned N  = N_DEF,
    parameter int unsigned Q  = Q_DEF,
    parameter int unsigned K  = K_DEF,
    parameter int unsigned AW = $clog2(K)
) (
    input  logic          clk,
    input  logic          rst,
    neuron_feeder_if.slave bus,
    input  logic          w_we,
    input  logic [AW-1:0] w_addr,
    input  logic [N-1:0]  w_data,
    input  logic          b_we,
    input  logic [N-1:0]  b_data,
    output logic          cfg_err,
    output logic          n_rst,
    output logic          n_inptReady,
    output logic [N-1:0]  n_w,
    output logic [N-1:0]  n_x,
    output logic [N-1:0]  n_b,
    input  logic [N-1:0]  n_out,
    input  logic          n_outReady
);

    localparam int unsigned CW = $clog2(K + 1);

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [AW-1:0] r_idx, w_idx_nxt;
    logic [N-1:0]  r_bias;
    logic          r_cfg_err;
    logic          r_n_inpt, w_n_inpt_nxt;
    logic [N-1:0]  r_n_w, w_n_w_nxt;
    logic [N-1:0]  r_n_x, w_n_x_nxt;
    logic [N-1:0]  r_n_b, w_n_b_nxt;
    logic          r_res_valid, w_res_valid_nxt;
    logic [N-1:0]  r_res_data;
    logic          w_cap;
    logic          w_hs;
    logic          w_cfg_open;
    logic [N-1:0]  w_rd_w;
    logic [N-1:0]  w_rd_x;
    logic          w_unused;

    assign w_hs       = bus.in_valid && (r_state == IDLE);
    assign w_cfg_open = (r_state == IDLE) && (r_cnt == '0);

    // Weight storage, written only while configuration is open.
    neuron_feeder_regfile #(.N(N), .K(K), .AW(AW)) u_wgt (
        .clk       (clk),
        .rst       (rst),
        .i_we      (w_we && w_cfg_open),
        .i_waddr   (w_addr),
        .i_wdata   (w_data),
        .i_raddr   (w_idx_nxt),
        .o_rdata_c (w_rd_w)
    );

    // Sample buffer, written at buf[count] on each input handshake.
    neuron_feeder_regfile #(.N(N), .K(K), .AW(AW)) u_smp (
        .clk       (clk),
        .rst       (rst),
        .i_we      (w_hs),
        .i_waddr   (AW'(r_cnt)),
        .i_wdata   (bus.in_x),
        .i_raddr   (w_idx_nxt),
        .o_rdata_c (w_rd_x)
    );

    // Next-state and next neuron-drive values; drives follow the upcoming state
    // so they are registered yet aligned with it.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_idx_nxt       = r_idx;
        w_res_valid_nxt = r_res_valid;
        w_cap           = 1'b0;
        w_n_inpt_nxt    = 1'b0;
        w_n_w_nxt       = '0;
        w_n_x_nxt       = '0;
        w_n_b_nxt       = '0;

        unique case (r_state)
            IDLE: begin
                if (w_hs) begin
                    w_cnt_nxt = r_cnt + CW'(1);
                    if (r_cnt == CW'(K - 1)) begin
                        w_state_nxt = CLR;
                    end
                end
            end
            CLR: begin
                w_state_nxt = STREAM;
                w_idx_nxt   = '0;
            end
            STREAM: begin
                if (r_idx == AW'(K - 1)) begin
                    w_state_nxt = BIAS;
                end else begin
                    w_idx_nxt = r_idx + AW'(1);
                end
            end
            BIAS: begin
                w_state_nxt = CAP;
            end
            CAP: begin
                w_state_nxt     = RESULT;
                w_cap           = 1'b1;
                w_res_valid_nxt = 1'b1;
            end
            RESULT: begin
                if (bus.res_ready) begin
                    w_state_nxt     = IDLE;
                    w_cnt_nxt       = '0;
                    w_res_valid_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        if (w_state_nxt == STREAM) begin
            w_n_inpt_nxt = 1'b1;
            w_n_w_nxt    = w_rd_w;
            w_n_x_nxt    = w_rd_x;
        end
        if (w_state_nxt == BIAS) begin
            w_n_b_nxt = r_bias;
        end
    end

    // State, counters, neuron drive and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_n_inpt    <= 1'b0;
            r_n_w       <= '0;
            r_n_x       <= '0;
            r_n_b       <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_idx       <= w_idx_nxt;
            r_n_inpt    <= w_n_inpt_nxt;
            r_n_w       <= w_n_w_nxt;
            r_n_x       <= w_n_x_nxt;
            r_n_b       <= w_n_b_nxt;
            r_res_valid <= w_res_valid_nxt;
            if (w_cap) begin
                r_res_data <= n_out;
            end
        end
    end

    // Bias register and dropped-write flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bias    <= '0;
            r_cfg_err <= 1'b0;
        end else begin
            if (b_we && w_cfg_open) begin
                r_bias <= b_data;
            end
            r_cfg_err <= (w_we || b_we) && !w_cfg_open;
        end
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.res_valid = r_res_valid;
    assign bus.res_data  = r_res_data;
    assign cfg_err       = r_cfg_err;
    assign n_rst         = rst || (r_state == CLR);
    assign n_inptReady   = r_n_inpt;
    assign n_w           = r_n_w;
    assign n_x           = r_n_x;
    assign n_b           = r_n_b;

    // Neuron status and the fractional-bit count are carried for the pair only.
    assign w_unused = ^{n_outReady, 1'(Q)};

endmodule
